multicycle_control_unit: RTL

Sequenced, parametrised control unit for the 16-bit RISC core. It replaces the purely combinational opcode decoder with a multi-cycle state machine. It adds an instruction-valid/ready handshake, configurable memory latency, acknowledged I/O strobes with timeout, per-operation ALU codes and explicit PC sequencing. It sits between the fetch stage (opcode source) and the datapath (register file, ALU, ROM, I/O port), keeps the same 3-bit ISA and drives the same datapath control signals.

---
 rtl/multicycle_control_unit.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Multi-cycle sequencer for the 16-bit RISC core. An opcode accepted in IDLE
// walks through EXEC, optionally MEM (ROM access) or IO (acknowledged strobe),
// and RETIRE, where register write-back and PC sequencing happen. All datapath
// controls are registered and decoded from the next-state view of the FSM, so
// no combinational path exists from opcode to any output.
module multicycle_control_unit #(
  parameter int ALU_OP_W   = 2,
  parameter int MEM_LAT    = 1,
  parameter int IO_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          opcode,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                zero_flag,
  input  logic                io_ack,
  output logic [ALU_OP_W-1:0] output_ALU,
  output logic                jump_neq,
  output logic                rom_read,
  output logic                rom_write,
  output logic                alu_select,
  output logic                sel_dst_reg,
  output logic                rom_to_reg,
  output logic                write_reg,
  output logic                write_strobe,
  output logic                read_strobe,
  output logic                pc_en,
  output logic                pc_load,
  output logic                busy,
  output logic                io_err
);

  localparam int IO_CNT_W = $clog2(IO_TIMEOUT + 1);

  // ISA opcodes
  localparam logic [2:0] OP_INPUT  = 3'b000;
  localparam logic [2:0] OP_OUTPUT = 3'b001;
  localparam logic [2:0] OP_LOAD   = 3'b010;
  localparam logic [2:0] OP_STORE  = 3'b011;
  localparam logic [2:0] OP_ADD    = 3'b100;
  localparam logic [2:0] OP_SUB    = 3'b101;
  localparam logic [2:0] OP_INV    = 3'b110;
  localparam logic [2:0] OP_JNE    = 3'b111;

  // Counter reload / limit values, sized to their counters
  localparam logic [3:0]          MEM_RELOAD = 4'(MEM_LAT - 1);
  localparam logic [IO_CNT_W-1:0] IO_LIMIT   = IO_CNT_W'(IO_TIMEOUT);
  localparam logic [IO_CNT_W-1:0] IO_ONE     = IO_CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXEC   = 3'd1,
    S_MEM    = 3'd2,
    S_IO     = 3'd3,
    S_RETIRE = 3'd4
  } state_e;

  // Bundle of every registered control output except the sticky io_err
  typedef struct packed {
    logic                instr_ready;
    logic                busy;
    logic [ALU_OP_W-1:0] alu;
    logic                jump_neq;
    logic                rom_read;
    logic                rom_write;
    logic                alu_select;
    logic                sel_dst_reg;
    logic                rom_to_reg;
    logic                write_reg;
    logic                write_strobe;
    logic                read_strobe;
    logic                pc_en;
    logic                pc_load;
  } ctrl_t;

  // ALU operation code presented during EXEC
  function automatic logic [ALU_OP_W-1:0] alu_code(input logic [2:0] op);
    logic [ALU_OP_W-1:0] code;
    case (op)
      OP_ADD:  code = ALU_OP_W'(2'b00);
      OP_SUB:  code = ALU_OP_W'(2'b01);
      OP_INV:  code = ALU_OP_W'(2'b11);
      OP_JNE:  code = ALU_OP_W'(2'b01);
      default: code = ALU_OP_W'(2'b10);
    endcase
    return code;
  endfunction

  // True for the register-to-register ALU instructions
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INV);
  endfunction

  // True for ROM accesses
  function automatic logic is_mem_op(input logic [2:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // Instructions that produce a register result
  function automatic logic writes_reg(input logic [2:0] op);
    return is_alu_op(op) || (op == OP_LOAD) || (op == OP_INPUT);
  endfunction

  // Control outputs as a pure function of FSM state and instruction context
  function automatic ctrl_t decode_ctrl(input state_e st, input logic [2:0] op,
                                        input logic taken, input logic tmo);
    ctrl_t c;
    logic  wr;
    c  = '0;
    wr = 1'b0;
    case (st)
      S_IDLE: begin
        c.instr_ready = 1'b1;
      end
      S_EXEC: begin
        c.busy        = 1'b1;
        c.alu         = alu_code(op);
        c.sel_dst_reg = is_alu_op(op);
        c.alu_select  = is_mem_op(op);
        c.jump_neq    = (op == OP_JNE);
      end
      S_MEM: begin
        c.busy       = 1'b1;
        c.alu_select = 1'b1;
        c.rom_read   = (op == OP_LOAD);
        c.rom_write  = (op == OP_STORE);
      end
      S_IO: begin
        c.busy         = 1'b1;
        c.read_strobe  = (op == OP_INPUT);
        c.write_strobe = (op == OP_OUTPUT);
      end
      S_RETIRE: begin
        // A timed-out INPUT has no valid data, so it must not write back
        wr            = writes_reg(op) && !tmo;
        c.busy        = 1'b1;
        c.write_reg   = wr;
        c.rom_to_reg  = wr && (op == OP_LOAD);
        c.sel_dst_reg = wr && (op == OP_INPUT);
        c.pc_load     = (op == OP_JNE) && taken;
        c.pc_en       = !((op == OP_JNE) && taken);
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  state_e              state_q,   state_d;
  logic [2:0]          op_q,      op_d;
  logic [3:0]          mem_cnt_q, mem_cnt_d;
  logic [IO_CNT_W-1:0] io_cnt_q,  io_cnt_d;
  logic                taken_q,   taken_d;
  logic                timeout_q, timeout_d;
  logic                io_err_q,  io_err_d;
  ctrl_t               ctrl_q,    ctrl_d;
  logic [IO_CNT_W-1:0] io_cnt_inc_s;

  // Saturating increment of the I/O wait counter
  always_comb begin
    if (io_cnt_q == '1) begin
      io_cnt_inc_s = io_cnt_q;
    end else begin
      io_cnt_inc_s = io_cnt_q + IO_ONE;
    end
  end

  // Next-state and next-context logic of the sequencer
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    mem_cnt_d = mem_cnt_q;
    io_cnt_d  = io_cnt_q;
    taken_d   = taken_q;
    timeout_d = timeout_q;
    io_err_d  = io_err_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d    = opcode;
          state_d = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_LOAD, OP_STORE: begin
            mem_cnt_d = MEM_RELOAD;
            state_d   = S_MEM;
          end
          OP_INPUT, OP_OUTPUT: begin
            io_cnt_d = '0;
            state_d  = S_IO;
          end
          OP_JNE: begin
            taken_d = !zero_flag;
            state_d = S_RETIRE;
          end
          default: begin
            state_d = S_RETIRE;
          end
        endcase
      end
      S_MEM: begin
        if (mem_cnt_q == 4'd0) begin
          state_d = S_RETIRE;
        end else begin
          mem_cnt_d = mem_cnt_q - 4'd1;
        end
      end
      S_IO: begin
        if (io_ack) begin
          state_d = S_RETIRE;
        end else if (io_cnt_inc_s == IO_LIMIT) begin
          io_cnt_d  = io_cnt_inc_s;
          timeout_d = 1'b1;
          io_err_d  = 1'b1;
          state_d   = S_RETIRE;
        end else begin
          io_cnt_d = io_cnt_inc_s;
          state_d  = S_IO;
        end
      end
      S_RETIRE: begin
        timeout_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ctrl_d = decode_ctrl(state_d, op_d, taken_d, timeout_d);
  end

  // State, context and registered control outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= 3'b000;
      mem_cnt_q <= 4'd0;
      io_cnt_q  <= '0;
      taken_q   <= 1'b0;
      timeout_q <= 1'b0;
      io_err_q  <= 1'b0;
      ctrl_q    <= decode_ctrl(S_IDLE, 3'b000, 1'b0, 1'b0);
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      mem_cnt_q <= mem_cnt_d;
      io_cnt_q  <= io_cnt_d;
      taken_q   <= taken_d;
      timeout_q <= timeout_d;
      io_err_q  <= io_err_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign instr_ready  = ctrl_q.instr_ready;
  assign busy         = ctrl_q.busy;
  assign output_ALU   = ctrl_q.alu;
  assign jump_neq     = ctrl_q.jump_neq;
  assign rom_read     = ctrl_q.rom_read;
  assign rom_write    = ctrl_q.rom_write;
  assign alu_select   = ctrl_q.alu_select;
  assign sel_dst_reg  = ctrl_q.sel_dst_reg;
  assign rom_to_reg   = ctrl_q.rom_to_reg;
  assign write_reg    = ctrl_q.write_reg;
  assign write_strobe = ctrl_q.write_strobe;
  assign read_strobe  = ctrl_q.read_strobe;
  assign pc_en        = ctrl_q.pc_en;
  assign pc_load      = ctrl_q.pc_load;
  assign io_err       = io_err_q;

endmodule
